// File: rtl/digit_serial_mac.sv
// ============================================================================
// Module   : digit_serial_mac
// Function : Digit-serial multiply-accumulate. Consumes b two bits per cycle
//            (LSB digit first) with Baugh-Wooley sign handling on the top
//            digit. Optional macro SATURATE_EN clamps the final accumulate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_serial_mac #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result
);

    localparam int DIGITS = WIDTH / 2;
    localparam int PW     = 2 * WIDTH;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_lastDigit = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_signed;
    logic                 r_clear;
    logic [PW-1:0]        r_product;
    logic [CNT_W-1:0]     r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;

    logic                 w_lastDigit;
    logic                 w_digitNeg;
    logic [PW-1:0]        w_aExt;
    logic [PW-1:0]        w_digitExt;
    logic [PW-1:0]        w_pp;
    logic [PW-1:0]        w_term;
    logic [PW-1:0]        w_prodNext;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH-1:0] w_prodExt;
    logic [ACC_WIDTH-1:0] w_nextAcc;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastDigit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Partial product: r_b shifts right each cycle so the current digit is
    // always in r_b[1:0]; only the top digit is negative-weighted.
    // ------------------------------------------------------------------
    assign w_lastDigit = (r_cnt == c_lastDigit);
    assign w_digitNeg  = r_signed & w_lastDigit & r_b[1];
    assign w_aExt      = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_digitExt  = {{(PW-2){w_digitNeg}}, r_b[1:0]};
    assign w_pp        = w_aExt * w_digitExt;
    assign w_term      = w_pp << {r_cnt, 1'b0};
    assign w_prodNext  = r_product + w_term;

    assign w_base    = r_clear ? '0 : r_acc;
    assign w_prodExt = r_signed ? ACC_WIDTH'($signed(w_prodNext)) : ACC_WIDTH'(w_prodNext);

`ifdef SATURATE_EN
    logic [ACC_WIDTH:0] w_sum;

    // One guard bit: carry-out flags unsigned overflow, a guard/MSB mismatch
    // flags signed overflow.
    always_comb begin
        w_sum = {r_signed & w_base[ACC_WIDTH-1], w_base}
              + {r_signed & w_prodExt[ACC_WIDTH-1], w_prodExt};
        if (!r_signed) begin
            w_nextAcc = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
        end else if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
            w_nextAcc = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            w_nextAcc = w_sum[ACC_WIDTH-1:0];
        end
    end
`else
    assign w_nextAcc = w_base + w_prodExt;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_clear   <= 1'b0;
            r_product <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_signed  <= signed_mode;
                        r_clear   <= acc_clear;
                        r_product <= '0;
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    r_product <= w_prodNext;
                    r_b       <= r_b >> 2;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_lastDigit) begin
                        r_acc <= w_nextAcc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_mac.sv
// ============================================================================
// Module   : tb_digit_serial_mac
// Function : Directed-vector bench for digit_serial_mac (32-bit and 16-bit
//            accumulator instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_mac;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready2;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        acc_clear;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [31:0] result;
    logic [15:0] result2;

    int nVec = 0;
    int nErr = 0;

`ifdef SATURATE_EN
    localparam logic [15:0] c_satExp = 16'd65535;
`else
    localparam logic [15:0] c_satExp = 16'd14464;
`endif

    digit_serial_mac #(.WIDTH(8), .ACC_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    digit_serial_mac #(.WIDTH(8), .ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .signed_mode(signed_mode), .acc_clear(acc_clear),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the first negedge with out_valid.
    task automatic startOp(input logic [7:0] opA, input logic [7:0] opB,
                           input logic sm, input logic clr);
        int cycles;
        a           = opA;
        b           = opB;
        signed_mode = sm;
        acc_clear   = clr;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        a           = 8'($urandom);
        b           = 8'($urandom);
        signed_mode = 1'($urandom);
        acc_clear   = 1'($urandom);
        cycles      = 0;
        @(negedge clk);
        while (!out_valid && cycles < 20) begin
            checkVal("busy_in_ready", in_ready, 1'b0);
            @(negedge clk);
            cycles++;
        end
        checkVal("latency", cycles, 4);
    endtask

    task automatic releaseOp();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("idle_in_ready", in_ready, 1'b1);
        checkVal("idle_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        acc_clear   = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("rst_in_ready", in_ready, 1'b1);
        checkVal("rst_out_valid", out_valid, 1'b0);
        checkVal("rst_result", result, 32'h0);

        // Unsigned full scale
        startOp(8'd255, 8'd255, 1'b0, 1'b1);
        checkVal("u_full", result, 32'h0000FE01);
        releaseOp();

        // Signed corners
        startOp(8'h80, 8'h80, 1'b1, 1'b1);
        checkVal("s_min_min", result, 32'h00004000);
        releaseOp();
        startOp(8'hFF, 8'd127, 1'b1, 1'b1);
        checkVal("s_m1_127", result, 32'hFFFFFF81);
        releaseOp();

        // Signed accumulate
        startOp(8'd3, 8'hFE, 1'b1, 1'b1);
        checkVal("acc_first", result, 32'hFFFFFFFA);
        releaseOp();
        startOp(8'd10, 8'd10, 1'b1, 1'b0);
        checkVal("acc_second", result, 32'h0000005E);
        releaseOp();

        // Backpressure: result held, new in_valid ignored
        out_ready = 1'b0;
        startOp(8'd12, 8'd34, 1'b0, 1'b1);
        checkVal("bp_result", result, 32'd408);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            a        = 8'd99;
            b        = 8'd99;
            @(negedge clk);
            checkVal("bp_out_valid", out_valid, 1'b1);
            checkVal("bp_stable", result, 32'd408);
            checkVal("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        releaseOp();
        checkVal("bp_after", result, 32'd408);

        // Reset during the second RUN cycle
        a        = 8'd50;
        b        = 8'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkVal("rst_async_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rst_run_in_ready", in_ready, 1'b1);
        checkVal("rst_run_out_valid", out_valid, 1'b0);
        checkVal("rst_run_result", result, 32'h0);
        @(negedge clk);
        startOp(8'd7, 8'd9, 1'b0, 1'b0);
        checkVal("post_rst_op", result, 32'd63);
        releaseOp();

        // Overflow of the 16-bit accumulator
        startOp(8'd200, 8'd200, 1'b0, 1'b1);
        checkVal("sat_first16", result2, 16'd40000);
        releaseOp();
        startOp(8'd200, 8'd200, 1'b0, 1'b0);
        checkVal("sat_second16", result2, c_satExp);
        checkVal("sat_second32", result, 32'd80000);
        releaseOp();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/digit_serial_mac.md
Name: digit_serial_mac

Overview:
- Sequential signed/unsigned multiply-accumulate. It consumes 2-bit digit partial products, one B-digit per cycle, and accumulates them into a wide register.
- It is the stage directly downstream of the 2-bit digit multiplier array in the precision-scalable datapath.
- It applies Baugh-Wooley-style sign handling on the most-significant digit row.
- Operands are accepted by valid/ready handshake. The accumulated result is presented on a valid/ready output.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4; digit count D = WIDTH/2.
- ACC_WIDTH, 32, accumulator width in bits; must be >= 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier, processed in 2-bit digits, LSB digit first.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- acc_clear  input  1  1 = this operation starts from acc = 0; sampled at accept.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  ACC_WIDTH  accumulator value.

Behaviour:
- Reset (async, any state): state = IDLE; in_ready = 1; out_valid = 0; result/acc = 0; product register = 0; digit counter = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready: latch a, b, signed_mode, acc_clear; product = 0; counter = 0; go to RUN.
  - RUN: in_ready = 0. Each cycle, product += (digit_k(b) * a) << 2k, where k = counter and digit_k = b[2k+1:2k].
    - Unsigned: digit and a are unsigned.
    - Signed: a is sign-extended. Digit k = D-1 is signed (value -2*b[2k+1] + b[2k]). Lower digits are unsigned.
    - product is 2*WIDTH bits and wraps modulo 2^(2*WIDTH); the exact product always fits.
    - Counter increments. On the cycle with counter = D-1, the transition to DONE also updates acc = base + ext(final product).
      - base = 0 if the latched acc_clear is set, else the current acc.
      - ext = sign-extension if signed_mode, else zero-extension.
      - The add wraps modulo 2^ACC_WIDTH unless SATURATE_EN is defined.
  - DONE: out_valid = 1; result = acc, held stable. On out_ready, go to IDLE and deassert out_valid. acc persists.
- Latency: accept in cycle T; RUN occupies T+1..T+D; out_valid = 1 from T+D+1. For WIDTH = 8: 4 RUN cycles, result 5 cycles after accept.
- Throughput: one operation per D+2 cycles when out_ready is held high.
  - in_ready is high only in IDLE; there is no overlap of accept and output.
- result always reflects acc, including in IDLE and RUN. It is only qualified by out_valid.
- in_valid while not in_ready: ignored; the upstream stage must hold its data.
- Inputs a, b, signed_mode, acc_clear may change freely after the accept edge.
- out_ready low in DONE: stay in DONE indefinitely, with result stable.
- Reset mid-RUN or mid-DONE: operation abandoned; all state and acc cleared; in_ready = 1 on the first cycle after reset deasserts.
- Zero operands: the normal cycle count still applies; there is no early termination.

Optional Feature:
- Macro: SATURATE_EN.
- When defined, the final accumulate clamps instead of wrapping:
  - Unsigned mode clamps to [0, 2^ACC_WIDTH - 1].
  - Signed mode clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1) - 1].
  - In unsigned mode, acc is treated as unsigned; in signed mode, as signed.
- When not defined, the add wraps modulo 2^ACC_WIDTH and there is no clamp logic.

Test Plan:
- Unsigned full scale: signed_mode = 0, acc_clear = 1, a = 255, b = 255.
  - Expect in_ready low for 5 cycles, out_valid at T+5, result = 65025 (0x0000FE01).
- Signed corner: signed_mode = 1, acc_clear = 1.
  - a = -128, b = -128 -> result 16384 (0x00004000).
  - Then a = -1, b = 127 -> result 0xFFFFFF81.
- Accumulate: signed_mode = 1.
  - a = 3, b = -2, acc_clear = 1 -> 0xFFFFFFFA.
  - Then a = 10, b = 10, acc_clear = 0 -> 94 (0x0000005E).
- Backpressure: out_ready held low for 7 cycles in DONE.
  - Expect out_valid and result stable, in_ready = 0, and a new in_valid ignored.
  - out_ready = 1 -> IDLE next cycle.
- Reset mid-RUN: assert rst during the 2nd RUN cycle.
  - Expect out_valid = 0, result = 0, in_ready = 1 immediately after reset deasserts.
  - The next operation 7 * 9 gives 63.
- Saturation: ACC_WIDTH = 16, unsigned, 200 * 200 twice (second with acc_clear = 0).
  - With SATURATE_EN: 65535.
  - Without SATURATE_EN: 14464.
